// File: rtl/frame_pp_buf_pkg.sv
// Shared defaults and write-side state encoding for the ping-pong frame buffer.
package frame_pp_buf_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_IMG_W     = 100;
    localparam int DEF_IMG_H     = 100;
    localparam int DEF_ADDR_W    = 14;
    localparam int DEF_FRAME_PIX = DEF_IMG_W * DEF_IMG_H;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_FILL = 1'b1
    } wr_state_e;

endpackage

// File: rtl/frame_pp_buf_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
module pp_sdp_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // No reset on the array or read register so the tools can map this to block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/frame_pp_buf.sv
// Ping-pong frame buffer: upstream fills one bank while the display reads the other;
// banks swap only at the read-frame boundary so the display never shows a torn frame.
module frame_pp_buf
    import frame_pp_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    input  logic              din_sop,
    output logic              wr_end,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_end,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic              rd_bank,
    output logic [7:0]        ovr_cnt
);

    localparam int FRAME_PIX = IMG_W * IMG_H;
    localparam int RAM_AW    = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);
    localparam logic [ADDR_W:0]   FRAME_END = (ADDR_W + 1)'(FRAME_PIX);

    wr_state_e         wr_state_q, wr_state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              pend_full_q, pend_full_d;
    logic              disp_vld_q, disp_vld_d;
    logic              rd_bank_q, rd_bank_d;
    logic [7:0]        ovr_cnt_q, ovr_cnt_d;
    logic              wr_end_q, wr_end_d;
    logic              dout_vld_q, dout_vld_d;
    logic              rd_sel_q, rd_sel_d;
    logic              rd_zero_q, rd_zero_d;

    logic              ram_we;
    logic [RAM_AW-1:0] ram_waddr;
    logic              ram_re;
    logic              rd_hit;
    logic              frame_done;
    logic              idle_sop;
    logic [DATA_W-1:0] rdata0, rdata1;

    always_comb begin
        wr_state_d  = wr_state_q;
        wr_addr_d   = wr_addr_q;
        pend_full_d = pend_full_q;
        disp_vld_d  = disp_vld_q;
        rd_bank_d   = rd_bank_q;
        ovr_cnt_d   = ovr_cnt_q;
        ram_we      = 1'b0;
        ram_waddr   = wr_addr_q[RAM_AW-1:0];
        frame_done  = 1'b0;
        idle_sop    = 1'b0;

        case (wr_state_q)
            WR_IDLE: begin
                if (din_vld && din_sop) begin
                    idle_sop   = 1'b1;
                    ram_we     = 1'b1;
                    ram_waddr  = '0;
                    wr_addr_d  = ADDR_W'(1);
                    wr_state_d = WR_FILL;
                    // A newer frame is replacing one that was never displayed.
                    if (pend_full_q) begin
                        pend_full_d = 1'b0;
                        if (ovr_cnt_q != 8'hFF) begin
                            ovr_cnt_d = ovr_cnt_q + 8'd1;
                        end
                    end
                end
            end
            WR_FILL: begin
                if (din_vld) begin
                    ram_we = 1'b1;
                    if (din_sop) begin
                        ram_waddr = '0;
                        wr_addr_d = ADDR_W'(1);
                    end else if (wr_addr_q == LAST_ADDR) begin
                        frame_done = 1'b1;
                        wr_addr_d  = '0;
                        wr_state_d = WR_IDLE;
                    end else begin
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                    end
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase

        // An IDLE sop is overwriting the pending bank, so it blocks any swap that cycle.
        if (!idle_sop) begin
            if ((frame_done && !disp_vld_q) || (rd_end && (pend_full_q || frame_done))) begin
                rd_bank_d   = ~rd_bank_q;
                pend_full_d = 1'b0;
                disp_vld_d  = 1'b1;
            end else if (frame_done) begin
                pend_full_d = 1'b1;
            end
        end
    end

    assign wr_end_d   = frame_done;
    assign rd_hit     = ({1'b0, rd_addr} < FRAME_END);
    assign ram_re     = rd_en && rd_hit;
    assign dout_vld_d = rd_en;
    assign rd_sel_d   = rd_bank_q;
    assign rd_zero_d  = !(rd_en && rd_hit && disp_vld_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q  <= WR_IDLE;
            wr_addr_q   <= '0;
            pend_full_q <= 1'b0;
            disp_vld_q  <= 1'b0;
            rd_bank_q   <= 1'b0;
            ovr_cnt_q   <= '0;
            wr_end_q    <= 1'b0;
            dout_vld_q  <= 1'b0;
            rd_sel_q    <= 1'b0;
            rd_zero_q   <= 1'b1;
        end else begin
            wr_state_q  <= wr_state_d;
            wr_addr_q   <= wr_addr_d;
            pend_full_q <= pend_full_d;
            disp_vld_q  <= disp_vld_d;
            rd_bank_q   <= rd_bank_d;
            ovr_cnt_q   <= ovr_cnt_d;
            wr_end_q    <= wr_end_d;
            dout_vld_q  <= dout_vld_d;
            rd_sel_q    <= rd_sel_d;
            rd_zero_q   <= rd_zero_d;
        end
    end

    // Write bank is always the one not on display.
    pp_sdp_ram #(.DATA_W(DATA_W), .DEPTH(FRAME_PIX), .AW(RAM_AW)) u_bank0 (
        .clk   (clk),
        .we    (ram_we && rd_bank_q),
        .waddr (ram_waddr),
        .wdata (din),
        .re    (ram_re),
        .raddr (rd_addr[RAM_AW-1:0]),
        .rdata (rdata0)
    );

    pp_sdp_ram #(.DATA_W(DATA_W), .DEPTH(FRAME_PIX), .AW(RAM_AW)) u_bank1 (
        .clk   (clk),
        .we    (ram_we && !rd_bank_q),
        .waddr (ram_waddr),
        .wdata (din),
        .re    (ram_re),
        .raddr (rd_addr[RAM_AW-1:0]),
        .rdata (rdata1)
    );

    assign dout     = rd_zero_q ? '0 : (rd_sel_q ? rdata1 : rdata0);
    assign dout_vld = dout_vld_q;
    assign wr_end   = wr_end_q;
    assign rd_bank  = rd_bank_q;
    assign ovr_cnt  = ovr_cnt_q;

endmodule

// File: tb/tb_frame_pp_buf.sv
// Directed bench for frame_pp_buf with a 4x2 frame: read tables plus hand sequences.
module tb_frame_pp_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din;
    logic        din_vld;
    logic        din_sop;
    logic        wr_end;
    logic        rd_en;
    logic [13:0] rd_addr;
    logic        rd_end;
    logic [15:0] dout;
    logic        dout_vld;
    logic        rd_bank;
    logic [7:0]  ovr_cnt;

    int total = 0;
    int bad   = 0;
    int wr_end_cnt = 0;

    typedef struct {
        logic [13:0] addr;
        logic [15:0] exp;
    } rd_vec_t;

    rd_vec_t vecs_a[6];

    frame_pp_buf #(.DATA_W(16), .IMG_W(4), .IMG_H(2), .ADDR_W(14)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .din_vld  (din_vld),
        .din_sop  (din_sop),
        .wr_end   (wr_end),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_end   (rd_end),
        .dout     (dout),
        .dout_vld (dout_vld),
        .rd_bank  (rd_bank),
        .ovr_cnt  (ovr_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_end) wr_end_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_pixels(input logic [15:0] base, input int n, input bit rd_end_on_last);
        for (int i = 0; i < n; i++) begin
            din     = base + 16'(i);
            din_vld = 1'b1;
            din_sop = (i == 0);
            rd_end  = rd_end_on_last && (i == n - 1);
            tick();
        end
        din_vld = 1'b0;
        din_sop = 1'b0;
        rd_end  = 1'b0;
    endtask

    task automatic do_read(input logic [13:0] a, output logic [15:0] d, output logic v);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        d       = dout;
        v       = dout_vld;
        rd_en   = 1'b0;
    endtask

    task automatic pulse_rd_end();
        rd_end = 1'b1;
        tick();
        rd_end = 1'b0;
    endtask

    initial begin
        logic [15:0] d;
        logic        v;
        int          base_cnt;

        vecs_a[0] = '{addr: 14'd0,   exp: 16'h1000};
        vecs_a[1] = '{addr: 14'd5,   exp: 16'h1005};
        vecs_a[2] = '{addr: 14'd3,   exp: 16'h1003};
        vecs_a[3] = '{addr: 14'd7,   exp: 16'h1007};
        vecs_a[4] = '{addr: 14'd8,   exp: 16'h0000};
        vecs_a[5] = '{addr: 14'd100, exp: 16'h0000};

        rst_n = 1'b0; din = '0; din_vld = 0; din_sop = 0; rd_en = 0; rd_addr = '0; rd_end = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check("reset_dout",     dout,     0);
        check("reset_dout_vld", dout_vld, 0);
        check("reset_rd_bank",  rd_bank,  0);
        check("reset_ovr_cnt",  ovr_cnt,  0);
        check("reset_wr_end",   wr_end,   0);

        do_read(14'd3, d, v);
        check("noframe_vld",  v, 1);
        check("noframe_dout", d, 0);
        tick();
        check("vld_follows_rd_en", dout_vld, 0);

        // Frame A: first frame swaps in immediately.
        base_cnt = wr_end_cnt;
        send_pixels(16'h1000, 8, 1'b0);
        check("a_first_swap", rd_bank, 1);
        tick();
        check("a_wr_end_once", wr_end_cnt - base_cnt, 1);
        for (int i = 0; i < 6; i++) begin
            do_read(vecs_a[i].addr, d, v);
            check($sformatf("a_read_%0d", vecs_a[i].addr), d, vecs_a[i].exp);
            check("a_read_vld", v, 1);
        end

        // Frame B waits for rd_end.
        send_pixels(16'h2000, 8, 1'b0);
        tick();
        do_read(14'd5, d, v);
        check("b_held_dout", d, 16'h1005);
        check("b_held_bank", rd_bank, 1);
        pulse_rd_end();
        check("b_swap_bank", rd_bank, 0);
        do_read(14'd5, d, v);
        check("b_read_5", d, 16'h2005);

        // C then D without rd_end: D overwrites C.
        base_cnt = wr_end_cnt;
        send_pixels(16'h4000, 8, 1'b0);
        send_pixels(16'h5000, 8, 1'b0);
        tick();
        check("cd_ovr_cnt", ovr_cnt, 1);
        check("cd_wr_end_twice", wr_end_cnt - base_cnt, 2);
        do_read(14'd0, d, v);
        check("cd_still_b", d, 16'h2000);
        pulse_rd_end();
        check("cd_bank", rd_bank, 1);
        do_read(14'd0, d, v);
        check("cd_read_d0", d, 16'h5000);

        // Mid-frame restart.
        base_cnt = wr_end_cnt;
        send_pixels(16'h6000, 3, 1'b0);
        send_pixels(16'h3000, 8, 1'b0);
        tick();
        check("restart_wr_end_once", wr_end_cnt - base_cnt, 1);
        check("restart_ovr_cnt", ovr_cnt, 1);
        pulse_rd_end();
        check("restart_bank", rd_bank, 0);
        do_read(14'd0, d, v);
        check("restart_read_0", d, 16'h3000);
        do_read(14'd2, d, v);
        check("restart_read_2", d, 16'h3002);

        // Completion coincident with rd_end.
        base_cnt = wr_end_cnt;
        send_pixels(16'h7000, 8, 1'b1);
        check("coinc_swap", rd_bank, 1);
        tick();
        check("coinc_wr_end", wr_end_cnt - base_cnt, 1);
        pulse_rd_end();
        check("coinc_pend_cleared", rd_bank, 1);
        do_read(14'd2, d, v);
        check("coinc_read_2", d, 16'h7002);

        // IDLE sop with rd_end: sop wins, no swap.
        send_pixels(16'h8000, 8, 1'b0);
        din = 16'h9000; din_vld = 1'b1; din_sop = 1'b1; rd_end = 1'b1;
        tick();
        rd_end = 1'b0;
        check("sop_prio_bank", rd_bank, 1);
        check("sop_prio_ovr", ovr_cnt, 2);
        din_sop = 1'b0;
        for (int i = 1; i < 8; i++) begin
            din = 16'h9000 + 16'(i);
            tick();
        end
        din_vld = 1'b0;
        pulse_rd_end();
        check("sop_prio_swap_later", rd_bank, 0);
        do_read(14'd1, d, v);
        check("sop_prio_read_1", d, 16'h9001);

        // Reset in the middle of a frame write, with a read in flight.
        din_vld = 1'b1; din_sop = 1'b1; din = 16'hA000; rd_en = 1'b1; rd_addr = 14'd1;
        tick();
        din_sop = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_dout",     dout,     0);
        check("rst_mid_dout_vld", dout_vld, 0);
        check("rst_mid_bank",     rd_bank,  0);
        check("rst_mid_ovr",      ovr_cnt,  0);
        check("rst_mid_wr_end",   wr_end,   0);
        din_vld = 1'b0; rd_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        do_read(14'd1, d, v);
        check("post_rst_vld",  v, 1);
        check("post_rst_dout", d, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
